// File: rtl/mp_reg_file_pkg.sv
// mp_rf_pkg: shared definitions for the multi-port register file.
//   - rfState_e   : clear-sweep FSM state encoding (ST_CLEAR, ST_RUN)
//   - DEF_*       : default data/address widths
//   - unpackField : extract field idx of width w from a flattened port bus
package mp_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Largest flattened bus / single field the unpack helper handles
    // (4 read ports x 64-bit data).
    localparam int BUS_MAX   = 256;
    localparam int FIELD_MAX = 64;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rfState_e;

    // Caller truncates the result to its own field width.
    function automatic logic [FIELD_MAX-1:0] unpackField(input logic [BUS_MAX-1:0] bus,
                                                         input int unsigned       idx,
                                                         input int unsigned       w);
        return FIELD_MAX'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/mp_reg_file_if.sv
// mp_reg_file_if: read/write bus of the multi-port register file.
//   rd_addr  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
//   wr_en    NUM_WR         per-port write enable
//   wr_addr  NUM_WR*ADDR_W  write addresses
//   wr_data  NUM_WR*DATA_W  write data
//   ready    1              clear sweep finished, writes accepted
//   wr_clash 1              sticky same-address dual-write flag
// master = pipeline side (ID/WB), slave = register file.
interface mp_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     ready;
    logic                     wr_clash;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, ready, wr_clash
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, ready, wr_clash
    );
endinterface

// File: rtl/mp_reg_file_clear_seq.sv
// rf_clear_seq: post-reset clear sweep for the register file.
// Writes zero to one entry per clock from index 0 up to DEPTH-1, then parks
// in RUN and raises ready until the next reset.
//   clk, rst_n  clock, async active-low reset (restarts the sweep)
//   clrWe       sweep write strobe (high for the whole CLEAR state)
//   clrAddr     entry being cleared this clock
//   ready       high in RUN
module rf_clear_seq
    import mp_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clrWe,
    output logic [ADDR_W-1:0] clrAddr,
    output logic              ready
);

    rfState_e          state, stateNxt;
    // One extra bit so the carry out of the last entry marks completion.
    logic [ADDR_W:0]   idx, idxNxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= stateNxt;
            idx   <= idxNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        idxNxt   = idx;
        clrWe    = 1'b0;
        ready    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clrWe  = 1'b1;
                idxNxt = idx + 1'b1;
                if (idxNxt[ADDR_W]) stateNxt = ST_RUN;
            end
            ST_RUN: begin
                ready = 1'b1;
            end
        endcase
    end

    assign clrAddr = idx[ADDR_W-1:0];

endmodule

// File: rtl/mp_reg_file.sv
// mp_reg_file: parametrised multi-port register file for the pipelined core.
// NUM_RD combinational read ports, NUM_WR synchronous write ports, optional
// hardwired-zero entry 0 and optional write->read bypass. Contents are
// zeroed by a one-entry-per-clock sweep after reset; until it finishes every
// read returns 0 and external writes are dropped.
//   clk    clock, rising edge
//   rst_n  async active-low reset
//   rf     mp_reg_file_if slave (rd_addr/rd_data, wr_en/wr_addr/wr_data,
//          ready, wr_clash)
module mp_reg_file
    import mp_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mp_reg_file_if.slave rf
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clrWe;
    logic [ADDR_W-1:0] clrAddr;
    logic              ready;

    rf_clear_seq #(.ADDR_W(ADDR_W)) uClrSeq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clrWe   (clrWe),
        .clrAddr (clrAddr),
        .ready   (ready)
    );

    // Unpacked views of the flattened port buses.
    logic [NUM_RD-1:0][ADDR_W-1:0] rdAddr;
    logic [NUM_RD-1:0][DATA_W-1:0] rdData;
    logic [NUM_WR-1:0][ADDR_W-1:0] wrAddr;
    logic [NUM_WR-1:0][DATA_W-1:0] wrData;

    for (genvar j = 0; j < NUM_WR; j++) begin : gWrUnpack
        assign wrAddr[j] = ADDR_W'(unpackField(BUS_MAX'(rf.wr_addr), j, ADDR_W));
        assign wrData[j] = DATA_W'(unpackField(BUS_MAX'(rf.wr_data), j, DATA_W));
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRdUnpack
        assign rdAddr[i] = ADDR_W'(unpackField(BUS_MAX'(rf.rd_addr), i, ADDR_W));
    end

    // Effective write ports: the sweep borrows port 0 until ready.
    logic [NUM_WR-1:0]             weEff;
    logic [NUM_WR-1:0][ADDR_W-1:0] waEff;
    logic [NUM_WR-1:0][DATA_W-1:0] wdEff;

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            weEff[j] = ready && rf.wr_en[j] && !(ZERO_EN && wrAddr[j] == '0);
            waEff[j] = wrAddr[j];
            wdEff[j] = wrData[j];
        end
        if (!ready) begin
            weEff[0] = clrWe;
            waEff[0] = clrAddr;
            wdEff[0] = '0;
        end
    end

    // Higher port index is applied last, so port 1 wins a same-address write.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_WR; j++) begin
            if (weEff[j]) mem[waEff[j]] <= wdEff[j];
        end
    end

    logic clashNow;
    logic wrClash;

    if (NUM_WR > 1) begin : gClash
        assign clashNow = ready && rf.wr_en[0] && rf.wr_en[1] &&
                          (wrAddr[0] == wrAddr[1]) &&
                          !(ZERO_EN && wrAddr[0] == '0);
    end else begin : gNoClash
        assign clashNow = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        wrClash <= 1'b0;
        else if (clashNow) wrClash <= 1'b1;
    end

    // Read mux per port: array, then bypass (later port overrides), then the
    // zero/not-ready forcing which beats everything.
    for (genvar i = 0; i < NUM_RD; i++) begin : gRd
        logic [DATA_W-1:0] rdVal;
        always_comb begin
            rdVal = mem[rdAddr[i]];
            if (BYPASS_EN) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (rf.wr_en[j] && wrAddr[j] == rdAddr[i]) rdVal = wrData[j];
                end
            end
            if (!ready || (ZERO_EN && rdAddr[i] == '0)) rdVal = '0;
        end
        assign rdData[i] = rdVal;
    end

    assign rf.rd_data  = rdData;
    assign rf.ready    = ready;
    assign rf.wr_clash = wrClash;

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file. Two instances share one stimulus stream:
//   A: ZERO_REG=1, BYPASS=1   B: ZERO_REG=0, BYPASS=0   (both 2R/2W, 32x32)
// A behavioural model (entry arrays, sweep count, clash flags) predicts every
// read port, ready and wr_clash each cycle.
module tb_mp_reg_file;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NR-1:0][AW-1:0] rdAddr;
    logic [NW-1:0]         wrEn;
    logic [NW-1:0][AW-1:0] wrAddr;
    logic [NW-1:0][DW-1:0] wrData;

    int checks   = 0;
    int failures = 0;

    mp_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) ifA ();
    mp_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) ifB ();

    assign ifA.rd_addr = rdAddr;
    assign ifA.wr_en   = wrEn;
    assign ifA.wr_addr = wrAddr;
    assign ifA.wr_data = wrData;
    assign ifB.rd_addr = rdAddr;
    assign ifB.wr_en   = wrEn;
    assign ifB.wr_addr = wrAddr;
    assign ifB.wr_data = wrData;

    mp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .ZERO_REG(1), .BYPASS(1)) dutA (.clk(clk), .rst_n(rst_n), .rf(ifA.slave));
    mp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .ZERO_REG(0), .BYPASS(0)) dutB (.clk(clk), .rst_n(rst_n), .rf(ifB.slave));

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] memA [DEPTH];
    logic [DW-1:0] memB [DEPTH];
    bit            clashA, clashB;
    int            sweepCnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] expRd(input bit zero, input bit byp,
                                            input logic [AW-1:0] ra, input logic [DW-1:0] stored);
        if (sweepCnt < DEPTH) return '0;
        if (zero && ra == 0) return '0;
        if (byp) begin
            if (wrEn[1] && wrAddr[1] == ra) return wrData[1];
            if (wrEn[0] && wrAddr[0] == ra) return wrData[0];
        end
        return stored;
    endfunction

    task automatic checkOutputs();
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("A.rd%0d", i), ifA.rd_data[i*DW +: DW],
                expRd(1'b1, 1'b1, rdAddr[i], memA[rdAddr[i]]));
            chk($sformatf("B.rd%0d", i), ifB.rd_data[i*DW +: DW],
                expRd(1'b0, 1'b0, rdAddr[i], memB[rdAddr[i]]));
        end
        chk("A.ready", ifA.ready, sweepCnt >= DEPTH);
        chk("B.ready", ifB.ready, sweepCnt >= DEPTH);
        chk("A.clash", ifA.wr_clash, clashA);
        chk("B.clash", ifB.wr_clash, clashB);
    endtask

    // Effect of one rising edge with the currently held inputs.
    task automatic updateModel();
        if (!rst_n) return;
        if (sweepCnt < DEPTH) begin
            sweepCnt++;
            if (sweepCnt == DEPTH) begin
                for (int k = 0; k < DEPTH; k++) begin
                    memA[k] = '0;
                    memB[k] = '0;
                end
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wrEn[j]) begin
                    if (wrAddr[j] != 0) memA[wrAddr[j]] = wrData[j];
                    memB[wrAddr[j]] = wrData[j];
                end
            end
            if (wrEn == 2'b11 && wrAddr[0] == wrAddr[1]) begin
                clashB = 1'b1;
                if (wrAddr[0] != 0) clashA = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic assertReset();
        rst_n    = 1'b0;
        sweepCnt = 0;
        clashA   = 1'b0;
        clashB   = 1'b0;
    endtask

    task automatic zeroIn();
        rdAddr = '0;
        wrEn   = '0;
        wrAddr = '0;
        wrData = '0;
    endtask

    task automatic randIn(input int aMax);
        for (int i = 0; i < NR; i++) rdAddr[i] = AW'($urandom_range(0, aMax));
        for (int j = 0; j < NW; j++) begin
            wrEn[j]   = 1'($urandom_range(0, 1));
            wrAddr[j] = AW'($urandom_range(0, aMax));
            wrData[j] = $urandom;
        end
    endtask

    task automatic readAll();
        for (int i = 0; i < DEPTH; i++) begin
            zeroIn();
            rdAddr[0] = AW'(i);
            rdAddr[1] = AW'(DEPTH - 1 - i);
            cycle();
        end
    endtask

    initial begin
        zeroIn();
        #1 assertReset();
        cycle();
        cycle();
        rst_n = 1'b1;

        // First sweep under random traffic, then some accepted writes.
        repeat (DEPTH + 4) begin
            randIn(DEPTH - 1);
            cycle();
        end

        // Fill every entry with a marker, then check a fresh reset clears it.
        for (int i = 0; i < DEPTH; i++) begin
            zeroIn();
            wrEn[0]   = 1'b1;
            wrAddr[0] = AW'(i);
            wrData[0] = 32'hDEADBEEF;
            rdAddr[0] = AW'(i);
            cycle();
        end
        zeroIn();
        assertReset();
        cycle();
        rst_n = 1'b1;
        repeat (DEPTH) begin
            zeroIn();
            rdAddr[0] = AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        readAll();

        // Same-cycle bypass and next-cycle read of a port-0 write.
        zeroIn();
        wrEn[0] = 1'b1; wrAddr[0] = 5; wrData[0] = 32'h12345678; rdAddr[0] = 5;
        cycle();
        zeroIn();
        rdAddr[1] = 5;
        cycle();

        // Write to entry 0.
        zeroIn();
        wrEn[0] = 1'b1; wrAddr[0] = 0; wrData[0] = 32'hFFFFFFFF;
        cycle();
        zeroIn();
        cycle();
        cycle();

        // Dual write to entry 0, then dual write to entry 9.
        zeroIn();
        wrEn = 2'b11; wrData[0] = 32'h1; wrData[1] = 32'h2;
        cycle();
        zeroIn();
        cycle();
        wrEn = 2'b11; wrAddr[0] = 9; wrAddr[1] = 9;
        wrData[0] = 32'hA; wrData[1] = 32'hB; rdAddr[0] = 9;
        cycle();
        zeroIn();
        rdAddr[0] = 9;
        cycle();
        cycle();

        // Reset pulsed mid-sweep at index 17, with writes during CLEAR.
        assertReset();
        cycle();
        rst_n = 1'b1;
        repeat (17) begin
            randIn(DEPTH - 1);
            cycle();
        end
        assertReset();
        randIn(DEPTH - 1);
        cycle();
        rst_n = 1'b1;
        repeat (DEPTH + 2) begin
            randIn(DEPTH - 1);
            wrEn[1] = 1'b0;
            cycle();
        end
        readAll();

        // Dense random traffic over a few addresses for bypass/clash overlap.
        repeat (300) begin
            randIn(7);
            cycle();
        end
        repeat (200) begin
            randIn(DEPTH - 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
